// File: rtl/uart_cmd_ctrl.sv
// Frame sequencer behind the UART receiver: SYNC, CMD, LEN, payload, CHK with an
// inter-byte timeout; holds good commands until acked and pulses one error per cause.
module uart_cmd_ctrl #(
  parameter int          MAX_LEN     = 16,
  parameter int          TIMEOUT_CYC = 20000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic                   in_rx_ready,
  input  logic [7:0]             in_rx_data,
  input  logic                   in_cmd_ack,
  output logic                   out_cmd_valid,
  output logic [7:0]             out_cmd_code,
  output logic [LW-1:0]          out_cmd_len,
  output logic [8*MAX_LEN-1:0]   out_cmd_payload,
  output logic                   out_busy,
  output logic                   out_err_chk,
  output logic                   out_err_len,
  output logic                   out_err_tmo,
  output logic                   out_err_ovr
);

  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD
  } state_e;

  state_e                 state_q;
  logic [7:0]             code_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          idx_q;
  logic [8*MAX_LEN-1:0]   payload_q;
  logic [7:0]             chkSum_q;
  logic [TW-1:0]          timer_q;
  logic                   cmdValid_q;
  logic                   busy_q;
  logic                   errChk_q;
  logic                   errLen_q;
  logic                   errTmo_q;
  logic                   errOvr_q;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      payload_q  <= '0;
      chkSum_q   <= '0;
      timer_q    <= '0;
      cmdValid_q <= 1'b0;
      busy_q     <= 1'b0;
      errChk_q   <= 1'b0;
      errLen_q   <= 1'b0;
      errTmo_q   <= 1'b0;
      errOvr_q   <= 1'b0;
    end else begin
      errChk_q <= 1'b0;
      errLen_q <= 1'b0;
      errTmo_q <= 1'b0;
      errOvr_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (in_rx_ready && (in_rx_data == SYNC_BYTE)) begin
            state_q   <= S_CMD;
            busy_q    <= 1'b1;
            payload_q <= '0;
            len_q     <= '0;
            chkSum_q  <= '0;
          end
        end

        S_HOLD: begin
          // Anything arriving here is lost, even a SYNC in the ack cycle.
          timer_q <= '0;
          if (in_rx_ready) begin
            errOvr_q <= 1'b1;
          end
          if (in_cmd_ack) begin
            state_q    <= S_IDLE;
            cmdValid_q <= 1'b0;
          end
        end

        default: begin
          if (in_rx_ready) begin
            timer_q <= '0;
            case (state_q)
              S_CMD: begin
                code_q   <= in_rx_data;
                chkSum_q <= in_rx_data;
                state_q  <= S_LEN;
              end
              S_LEN: begin
                if (in_rx_data > MAX_LEN_B) begin
                  errLen_q <= 1'b1;
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                end else begin
                  len_q    <= LW'(in_rx_data);
                  chkSum_q <= chkSum_q ^ in_rx_data;
                  idx_q    <= '0;
                  state_q  <= (in_rx_data == 8'd0) ? S_CHK : S_DATA;
                end
              end
              S_DATA: begin
                for (int i = 0; i < MAX_LEN; i++) begin
                  if (idx_q == LW'(i)) begin
                    payload_q[i*8 +: 8] <= in_rx_data;
                  end
                end
                chkSum_q <= chkSum_q ^ in_rx_data;
                if (idx_q == (len_q - LW'(1))) begin
                  state_q <= S_CHK;
                end else begin
                  idx_q <= idx_q + LW'(1);
                end
              end
              S_CHK: begin
                busy_q <= 1'b0;
                if (in_rx_data == chkSum_q) begin
                  state_q    <= S_HOLD;
                  cmdValid_q <= 1'b1;
                end else begin
                  errChk_q <= 1'b1;
                  state_q  <= S_IDLE;
                end
              end
              default: begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end else if (timer_q == TMO_LAST) begin
            // Checked only when no byte arrived, so a byte on the expiry cycle wins.
            errTmo_q <= 1'b1;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
      endcase
    end
  end

  assign out_cmd_valid   = cmdValid_q;
  assign out_cmd_code    = code_q;
  assign out_cmd_len     = len_q;
  assign out_cmd_payload = payload_q;
  assign out_busy        = busy_q;
  assign out_err_chk     = errChk_q;
  assign out_err_len     = errLen_q;
  assign out_err_tmo     = errTmo_q;
  assign out_err_ovr     = errOvr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: good commands go through a scoreboard queue,
// error pulses are counted by a monitor and checked against the directed sequence.
module tb_uart_cmd_ctrl;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 40;
  localparam int LW          = $clog2(MAX_LEN + 1);
  localparam int PW          = 8 * MAX_LEN;

  typedef struct {
    logic [7:0]    code;
    logic [LW-1:0] len;
    logic [PW-1:0] payload;
  } exp_t;

  logic           in_clk;
  logic           in_rst;
  logic           in_rx_ready;
  logic [7:0]     in_rx_data;
  logic           in_cmd_ack;
  logic           out_cmd_valid;
  logic [7:0]     out_cmd_code;
  logic [LW-1:0]  out_cmd_len;
  logic [PW-1:0]  out_cmd_payload;
  logic           out_busy;
  logic           out_err_chk;
  logic           out_err_len;
  logic           out_err_tmo;
  logic           out_err_ovr;

  int   compared   = 0;
  int   mismatched = 0;
  int   chkCnt     = 0;
  int   lenCnt     = 0;
  int   tmoCnt     = 0;
  int   ovrCnt     = 0;
  int   popCnt     = 0;
  int   pushCnt    = 0;
  logic prevValid  = 1'b0;
  exp_t sb[$];

  uart_cmd_ctrl #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_rx_ready     (in_rx_ready),
    .in_rx_data      (in_rx_data),
    .in_cmd_ack      (in_cmd_ack),
    .out_cmd_valid   (out_cmd_valid),
    .out_cmd_code    (out_cmd_code),
    .out_cmd_len     (out_cmd_len),
    .out_cmd_payload (out_cmd_payload),
    .out_busy        (out_busy),
    .out_err_chk     (out_err_chk),
    .out_err_len     (out_err_len),
    .out_err_tmo     (out_err_tmo),
    .out_err_ovr     (out_err_ovr)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag order: {valid, busy, err_chk, err_len, err_tmo, err_ovr}
  task automatic checkFlags(input string tag, input logic [5:0] exp);
    checkOutput(tag, PW'({out_cmd_valid, out_busy, out_err_chk, out_err_len, out_err_tmo, out_err_ovr}),
                PW'(exp));
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    in_rx_ready = 1'b1;
    in_rx_data  = b;
    tick();
    in_rx_ready = 1'b0;
    in_rx_data  = 8'h00;
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i]);
  endtask

  task automatic pushExpected(input logic [7:0] code, input logic [7:0] pl[$]);
    exp_t e;
    e.code    = code;
    e.len     = LW'(pl.size());
    e.payload = '0;
    foreach (pl[i]) e.payload[i*8 +: 8] = pl[i];
    sb.push_back(e);
    pushCnt++;
  endtask

  task automatic ackCmd(input string tag);
    in_cmd_ack = 1'b1;
    tick();
    in_cmd_ack = 1'b0;
    checkFlags(tag, 6'b000000);
  endtask

  // Scoreboard and error-pulse monitor, sampled on the falling edge.
  always @(negedge in_clk) begin
    if (out_err_chk) chkCnt++;
    if (out_err_len) lenCnt++;
    if (out_err_tmo) tmoCnt++;
    if (out_err_ovr) ovrCnt++;
    if (out_cmd_valid && !prevValid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", PW'(1'b1), PW'(1'b0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        popCnt++;
        checkOutput("sb_code", PW'(out_cmd_code), PW'(e.code));
        checkOutput("sb_len", PW'(out_cmd_len), PW'(e.len));
        checkOutput("sb_payload", out_cmd_payload, e.payload);
      end
    end
    prevValid = out_cmd_valid;
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pl[$];

    in_rst      = 1'b1;
    in_rx_ready = 1'b0;
    in_rx_data  = 8'h00;
    in_cmd_ack  = 1'b0;
    repeat (3) tick();
    checkFlags("reset_flags", 6'b000000);
    checkOutput("reset_code", PW'(out_cmd_code), PW'(8'h00));
    checkOutput("reset_len", PW'(out_cmd_len), PW'(1'b0));
    checkOutput("reset_payload", out_cmd_payload, '0);
    in_rst = 1'b0;
    tick();

    $display("[TB] good frame with 3-byte payload");
    fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    sendBytes(fr);
    checkFlags("busy_before_chk", 6'b010000);
    pl = '{8'h11, 8'h22, 8'h33};
    pushExpected(8'h10, pl);
    applyStimulus(8'h13);
    checkFlags("valid_after_chk", 6'b100000);
    repeat (50) tick();
    checkFlags("hold_50_flags", 6'b100000);
    checkOutput("hold_code", PW'(out_cmd_code), PW'(8'h10));
    checkOutput("hold_len", PW'(out_cmd_len), PW'(5'd3));
    checkOutput("hold_payload", out_cmd_payload, PW'(24'h332211));
    in_cmd_ack = 1'b1;
    checkFlags("valid_in_ack_cycle", 6'b100000);
    in_cmd_ack = 1'b0;
    ackCmd("after_ack_1");

    $display("[TB] zero-length frame, then checksum error");
    pl = {};
    pushExpected(8'h7E, pl);
    fr = '{8'hA5, 8'h7E, 8'h00, 8'h7E};
    sendBytes(fr);
    checkFlags("zero_len_valid", 6'b100000);
    checkOutput("zero_len_len", PW'(out_cmd_len), PW'(1'b0));
    ackCmd("after_ack_2");
    fr = '{8'hA5, 8'h7E, 8'h00, 8'h7F};
    sendBytes(fr);
    checkFlags("chk_err_pulse", 6'b001000);
    tick();
    checkFlags("chk_err_single", 6'b000000);

    $display("[TB] length error, then good frame");
    fr = '{8'hA5, 8'h01, 8'h11};
    sendBytes(fr);
    checkFlags("len_err_pulse", 6'b000100);
    tick();
    checkFlags("len_err_single", 6'b000000);
    pl = '{8'h5A};
    pushExpected(8'h01, pl);
    fr = '{8'hA5, 8'h01, 8'h01, 8'h5A, 8'h5A};
    sendBytes(fr);
    checkFlags("after_len_err_valid", 6'b100000);
    ackCmd("after_ack_3");

    $display("[TB] inter-byte timeout");
    fr = '{8'hA5, 8'h01};
    sendBytes(fr);
    repeat (TIMEOUT_CYC - 1) tick();
    checkFlags("tmo_not_yet", 6'b010000);
    tick();
    checkFlags("tmo_pulse", 6'b000010);
    tick();
    checkFlags("tmo_single", 6'b000000);

    $display("[TB] byte on the expiry cycle");
    fr = '{8'hA5, 8'h01};
    sendBytes(fr);
    repeat (TIMEOUT_CYC - 1) tick();
    applyStimulus(8'h00);
    checkFlags("byte_wins_tmo", 6'b010000);
    pl = {};
    pushExpected(8'h01, pl);
    applyStimulus(8'h01);
    checkFlags("byte_wins_valid", 6'b100000);
    ackCmd("after_ack_4");

    $display("[TB] overrun in HOLD");
    pl = '{8'hC3};
    pushExpected(8'h20, pl);
    fr = '{8'hA5, 8'h20, 8'h01, 8'hC3, 8'hE2};
    sendBytes(fr);
    checkFlags("ovr_hold_valid", 6'b100000);
    applyStimulus(8'h55);
    checkFlags("ovr_pulse_1", 6'b100001);
    checkOutput("ovr_code_stable", PW'(out_cmd_code), PW'(8'h20));
    checkOutput("ovr_payload_stable", out_cmd_payload, PW'(8'hC3));
    tick();
    checkFlags("ovr_single", 6'b100000);
    in_cmd_ack = 1'b1;
    applyStimulus(8'hA5);
    in_cmd_ack = 1'b0;
    checkFlags("ovr_pulse_ack", 6'b000001);
    tick();
    checkFlags("sync_dropped_idle", 6'b000000);

    $display("[TB] reset mid-DATA");
    fr = '{8'hA5, 8'h02, 8'h04, 8'hAA};
    sendBytes(fr);
    checkFlags("mid_data_busy", 6'b010000);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    checkFlags("mid_reset_flags", 6'b000000);
    checkOutput("mid_reset_code", PW'(out_cmd_code), PW'(8'h00));
    checkOutput("mid_reset_payload", out_cmd_payload, '0);
    tick();
    checkFlags("mid_reset_no_err", 6'b000000);
    pl = '{8'hBB};
    pushExpected(8'h02, pl);
    fr = '{8'hA5, 8'h02, 8'h01, 8'hBB, 8'hB8};
    sendBytes(fr);
    checkFlags("post_reset_valid", 6'b100000);
    ackCmd("after_ack_5");
    repeat (3) tick();

    checkOutput("count_err_chk", PW'(chkCnt), PW'(1));
    checkOutput("count_err_len", PW'(lenCnt), PW'(1));
    checkOutput("count_err_tmo", PW'(tmoCnt), PW'(1));
    checkOutput("count_err_ovr", PW'(ovrCnt), PW'(2));
    checkOutput("sb_pending", PW'(sb.size()), PW'(0));
    checkOutput("sb_popped", PW'(popCnt), PW'(pushCnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Frame-level controller that sits behind the UART receiver and sequences its byte stream into validated command frames for the tester core. It consumes the receiver's one-cycle byte strobe and the byte value, then runs a sync/header/payload/checksum state machine with an inter-byte timeout. It holds each good command on an output register until the core acknowledges it. It reports checksum, length, timeout and overrun errors as single-cycle pulses.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (1..32)
TIMEOUT_CYC, 20000, clock cycles allowed between consecutive bytes of one frame
SYNC_BYTE, 8'hA5, frame start marker
LW, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)

Ports:
in_clk  input  1  clock
in_rst  input  1  synchronous reset, active-high
in_rx_ready  input  1  one-cycle strobe: in_rx_data holds a valid received byte
in_rx_data  input  8  received byte
in_cmd_ack  input  1  core has consumed the held command
out_cmd_valid  output  1  good command held on outputs
out_cmd_code  output  8  command byte
out_cmd_len  output  LW  payload length
out_cmd_payload  output  8*MAX_LEN  payload; byte i at bits [8i+7:8i]
out_busy  output  1  high in every state except IDLE and HOLD
out_err_chk  output  1  pulse: checksum mismatch
out_err_len  output  1  pulse: LEN > MAX_LEN
out_err_tmo  output  1  pulse: inter-byte timeout
out_err_ovr  output  1  pulse: byte dropped while in HOLD

Behaviour:
- Reset (in_rst=1 at a clock edge): state IDLE; all outputs 0; payload, length, checksum and timer cleared. Reset mid-frame or in HOLD discards the frame with no error pulse.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- Bytes are only acted on in cycles where in_rx_ready=1. In-frame states ignore in_rx_data otherwise.
- IDLE: byte == SYNC_BYTE -> CMD, and clear payload, checksum and timer. Any other byte is ignored silently.
- CMD: latch the code; checksum = byte; -> LEN.
- LEN: byte > MAX_LEN -> out_err_len pulse, -> IDLE.
- LEN: byte == 0 -> CHK; otherwise -> DATA with index = 0. In both cases XOR the byte into the checksum.
- DATA: store the byte at the current index; XOR it into the checksum; increment the index. When index reaches LEN-1 at this byte, go to CHK.
- CHK: byte == checksum -> HOLD, with out_cmd_valid=1 from the next cycle (one cycle after the CHK strobe). Mismatch -> out_err_chk pulse, -> IDLE.
- HOLD: outputs are stable and out_cmd_valid=1 until a cycle with in_cmd_ack=1, then -> IDLE and out_cmd_valid=0 from the next cycle.
- HOLD: any byte arriving while in HOLD, including in the ack cycle, is dropped and gives an out_err_ovr pulse. A SYNC byte in the ack cycle is also dropped.
- in_cmd_ack outside HOLD is ignored.
- Timeout: the timer runs in CMD, LEN, DATA and CHK and restarts on every accepted byte. It is held at 0 in IDLE and HOLD.
- Timer reaching TIMEOUT_CYC-1 without a byte: out_err_tmo pulse, -> IDLE.
- If a byte and timer expiry occur in the same cycle, the byte wins and there is no timeout.
- Error pulses are exactly one cycle wide and registered, asserted the cycle after the cause. At most one error pulse per cycle.
- Payload bytes at index >= LEN read as 0. out_cmd_len and out_cmd_code are valid only while out_cmd_valid=1 and hold their value until the next SYNC is accepted.
- All state is in in_clk flops; no combinational path from inputs to outputs.

Test Plan:
- Good frame A5 10 03 11 22 33 10 (CHK = 10^03^11^22^33 = 0x13, so the last byte sent is 0x13, not 0x10) -> out_cmd_valid one cycle after the CHK strobe, code=0x10, len=3, payload[23:0]=0x332211, upper bytes 0. Hold for 50 cycles with no ack, then ack -> valid drops next cycle.
- Zero-length frame A5 7E 00 7E -> valid, code=0x7E, len=0. Then bad frame A5 7E 00 7F -> out_err_chk single pulse, no valid.
- Length error A5 01 11 (17 > MAX_LEN) -> out_err_len pulse, back in IDLE. A following good frame is accepted normally.
- Timeout: A5 01, then a gap of TIMEOUT_CYC cycles -> out_err_tmo pulse once. Repeat with the byte arriving on exactly the expiry cycle -> no timeout, frame continues.
- Overrun: in HOLD, send 0x55 and, separately, a byte coinciding with in_cmd_ack -> out_err_ovr pulse each time. Outputs unchanged before ack; IDLE after.
- Reset mid-DATA (after A5 02 04 AA) -> all outputs 0, no error pulse. The next full frame A5 02 01 BB BB^02^01 (=0xB8) is accepted.
